// File: rtl/motoro3_pkg.sv
// Shared encodings for the motoro3 gate driver: phase FSM states, decoded
// phase targets, step-index boundaries and m3gate bit positions.
package motoro3_pkg;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2,
    PH_DEAD = 2'd3
  } phase_state_t;

  typedef enum logic [1:0] {
    TGT_FLOAT = 2'd0,
    TGT_HIGH  = 2'd1,
    TGT_LOW   = 2'd2
  } target_t;

  localparam logic [3:0] STEP_IDLE    = 4'd0;
  localparam logic [3:0] STEP_MAX     = 4'd12;
  localparam logic [3:0] STEP_HIGH_LO = 4'd1;
  localparam logic [3:0] STEP_HIGH_HI = 4'd4;
  localparam logic [3:0] STEP_LOW_LO  = 4'd7;
  localparam logic [3:0] STEP_LOW_HI  = 4'd10;

  localparam int GATE_AL = 0;
  localparam int GATE_AH = 1;
  localparam int GATE_BL = 2;
  localparam int GATE_BH = 3;
  localparam int GATE_CL = 4;
  localparam int GATE_CH = 5;

  // Idle, the two float windows and the illegal codes all decode to FLOAT.
  function automatic target_t decode_step(input logic [3:0] step);
    if (step >= STEP_HIGH_LO && step <= STEP_HIGH_HI) return TGT_HIGH;
    if (step >= STEP_LOW_LO && step <= STEP_LOW_HI) return TGT_LOW;
    return TGT_FLOAT;
  endfunction

endpackage

// File: rtl/motoro3_phase_deadtime.sv
// One half-bridge: OFF/HIGH/LOW/DEAD state machine with a dead-time counter
// that keeps both gates off for DEAD_CYCLES cycles whenever a driven state ends.
module motoro3_phase_deadtime
  import motoro3_pkg::*;
#(
  parameter int DEAD_CYCLES = 20,
  parameter int DEAD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] target,
  output logic       gateH,
  output logic       gateL,
  output logic       dead
);

  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES - 1);

  phase_state_t      state_q, state_d;
  phase_state_t      tgt_state;
  logic [DEAD_W-1:0] cnt_q, cnt_d;
  logic              gate_h_q, gate_h_d;
  logic              gate_l_q, gate_l_d;
  logic              dead_q, dead_d;

  always_comb begin
    tgt_state = PH_OFF;
    case (target_t'(target))
      TGT_HIGH: tgt_state = PH_HIGH;
      TGT_LOW:  tgt_state = PH_LOW;
      default:  tgt_state = PH_OFF;
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PH_OFF: state_d = tgt_state;
      PH_HIGH, PH_LOW: begin
        if (tgt_state != state_q) begin
          state_d = PH_DEAD;
          cnt_d   = DEAD_LOAD;
        end
      end
      // Target is ignored until the countdown expires, so a brief FLOAT
      // glitch cannot shorten the off-time.
      PH_DEAD: begin
        if (cnt_q == '0) state_d = tgt_state;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = PH_OFF;
    endcase

    gate_h_d = (state_d == PH_HIGH);
    gate_l_d = (state_d == PH_LOW);
    dead_d   = (state_d == PH_DEAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PH_OFF;
      cnt_q    <= '0;
      gate_h_q <= 1'b0;
      gate_l_q <= 1'b0;
      dead_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
      dead_q   <= dead_d;
    end
  end

  assign gateH = gate_h_q;
  assign gateL = gate_l_q;
  assign dead  = dead_q;

endmodule

// File: rtl/motoro3_gate_driver.sv
// Three-phase gate driver: decodes the step indices into per-phase targets,
// detects illegal step combinations and drives three dead-time half-bridges.
module motoro3_gate_driver
  import motoro3_pkg::*;
#(
  parameter int DEAD_CYCLES = 20,
  parameter int DEAD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m3start,
  input  logic [3:0] m3stepA,
  input  logic [3:0] m3stepB,
  input  logic [3:0] m3stepC,
  output logic [5:0] m3gate,
  output logic [2:0] m3dead,
  output logic       m3fault
);

  logic [2:0][3:0] steps;
  logic [2:0][1:0] dec;
  logic [2:0][1:0] tgt;
  logic [2:0]      is_high, is_low;
  logic [2:0]      gate_h, gate_l, dead;
  logic            any_illegal, all_run, one_each;
  logic            fault_now, force_float;
  logic            fault_q, fault_d;

  assign steps = {m3stepC, m3stepB, m3stepA};

  always_comb begin
    any_illegal = 1'b0;
    all_run     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dec[i]     = decode_step(steps[i]);
      is_high[i] = (dec[i] == TGT_HIGH);
      is_low[i]  = (dec[i] == TGT_LOW);
      if (steps[i] > STEP_MAX) any_illegal = 1'b1;
      if (steps[i] == STEP_IDLE || steps[i] > STEP_MAX) all_run = 1'b0;
    end
    // With three phases, one HIGH plus one LOW leaves exactly one FLOAT.
    one_each    = $onehot(is_high) && $onehot(is_low);
    fault_now   = m3start && (any_illegal || (all_run && !one_each));
    fault_d     = m3start && (fault_q || fault_now);
    force_float = !m3start || fault_now || fault_q;
    for (int i = 0; i < 3; i++) begin
      tgt[i] = force_float ? TGT_FLOAT : dec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  for (genvar g = 0; g < 3; g++) begin : g_phase
    motoro3_phase_deadtime #(
      .DEAD_CYCLES(DEAD_CYCLES),
      .DEAD_W     (DEAD_W)
    ) u_phase (
      .clk   (clk),
      .rst   (rst),
      .target(tgt[g]),
      .gateH (gate_h[g]),
      .gateL (gate_l[g]),
      .dead  (dead[g])
    );
  end

  always_comb begin
    m3gate          = '0;
    m3gate[GATE_AL] = gate_l[0];
    m3gate[GATE_AH] = gate_h[0];
    m3gate[GATE_BL] = gate_l[1];
    m3gate[GATE_BH] = gate_h[1];
    m3gate[GATE_CL] = gate_l[2];
    m3gate[GATE_CH] = gate_h[2];
  end

  assign m3dead  = dead;
  assign m3fault = fault_q;

endmodule
